zif_clock_sequencer: RTL

//  Programmable burst/clock generator for a single ZIF pin. Generates a square wave from
//  i_clock_20M with a host-set half period and pulse count, using a start/busy/done handshake.

---
 rtl/zif_clk_pkg.sv | 13 +
 rtl/zif_clock_sequencer_if.sv | 27 ++
 rtl/zif_clk_halfcnt.sv | 32 +++
 rtl/zif_clock_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/zif_clk_pkg.sv
// Shared types and constants for the ZIF pin clock sequencer.
package zif_clk_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam logic [15:0] HALF_1KHZ = 16'd9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/zif_clock_sequencer_if.sv
// Host-side command/status bundle of the ZIF clock sequencer.
interface zif_clock_sequencer_if
  import zif_clk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic [CNT_W-1:0] i_half_period;
  logic [CNT_W-1:0] i_pulse_count;
  logic             i_start;
  logic             i_stop;
  logic             o_clk;
  logic             o_oe;
  logic             o_busy;
  logic             o_done;
  logic             o_abort;
  logic [CNT_W-1:0] o_edges;

  modport master (
    output i_half_period, i_pulse_count, i_start, i_stop,
    input  o_clk, o_oe, o_busy, o_done, o_abort, o_edges
  );

  modport slave (
    input  i_half_period, i_pulse_count, i_start, i_stop,
    output o_clk, o_oe, o_busy, o_done, o_abort, o_edges
  );
endinterface

// File: rtl/zif_clk_halfcnt.sv
// Loadable half-period down-counter; tc strobes on the last cycle of each half period
// and the counter reloads itself from the latched period.
module zif_clk_halfcnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] cnt_r;

  // period latch and down-counter with automatic reload at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_r <= {CNT_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (load) begin
      period_r <= load_val;
      cnt_r    <= load_val;
    end else if (en) begin
      cnt_r <= (cnt_r == {CNT_W{1'b0}}) ? period_r : cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = en & (cnt_r == {CNT_W{1'b0}});
endmodule

// File: rtl/zif_clock_sequencer.sv
// Burst clock generator for one ZIF pin with start/busy/done handshake.
// Optional build macro CLK_SEQ_FREERUN_EN: a pulse count of 0 runs until i_stop.
module zif_clock_sequencer
  import zif_clk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  i_clock_20M,
  input  logic                  i_reset_n,
  zif_clock_sequencer_if.slave  bus
);
  seq_state_e       state_r, state_s;
  logic             clk_r, clk_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             abort_r, abort_s;
  logic [CNT_W-1:0] edges_r, edges_s;
  logic [CNT_W-1:0] pc_r, pc_s;
  logic             load_s, run_s, tc_s;
  logic             zero_done_s, last_s;

  zif_clk_halfcnt #(.CNT_W(CNT_W)) u_halfcnt (
    .clk      (i_clock_20M),
    .rst_n    (i_reset_n),
    .load     (load_s),
    .load_val (bus.i_half_period),
    .en       (run_s),
    .tc       (tc_s)
  );

`ifdef CLK_SEQ_FREERUN_EN
  assign zero_done_s = 1'b0;
  assign last_s      = (pc_r != {CNT_W{1'b0}}) && (edges_r == pc_r);
`else
  assign zero_done_s = (bus.i_pulse_count == {CNT_W{1'b0}});
  assign last_s      = (edges_r == pc_r);
`endif

  // state and registered outputs
  always_ff @(posedge i_clock_20M) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
      clk_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      edges_r <= {CNT_W{1'b0}};
      pc_r    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      clk_r   <= clk_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      abort_r <= abort_s;
      edges_r <= edges_s;
      pc_r    <= pc_s;
    end
  end

  // next-state and next-output decode
  always_comb begin
    state_s = state_r;
    clk_s   = clk_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    abort_s = abort_r;
    edges_s = edges_r;
    pc_s    = pc_r;
    load_s  = 1'b0;
    run_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // stop beats a simultaneous start
        if (bus.i_start && !bus.i_stop) begin
          pc_s    = bus.i_pulse_count;
          abort_s = 1'b0;
          load_s  = 1'b1;
          if (zero_done_s) begin
            state_s = DONE;
            done_s  = 1'b1;
            edges_s = {CNT_W{1'b0}};
          end else begin
            state_s = RUN;
            busy_s  = 1'b1;
            clk_s   = 1'b1;
            edges_s = CNT_W'(1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        run_s = 1'b1;
        if (bus.i_stop) begin
          state_s = DONE;
          done_s  = 1'b1;
          abort_s = 1'b1;
          busy_s  = 1'b0;
          clk_s   = 1'b0;
        end else if (tc_s) begin
          if (clk_r) begin
            clk_s = 1'b0;
          end else if (last_s) begin
            state_s = DONE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            clk_s   = 1'b0;
          end else begin
            clk_s   = 1'b1;
            edges_s = edges_r + CNT_W'(1);
          end
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        clk_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign bus.o_clk   = clk_r;
  assign bus.o_oe    = busy_r;
  assign bus.o_busy  = busy_r;
  assign bus.o_done  = done_r;
  assign bus.o_abort = abort_r;
  assign bus.o_edges = edges_r;
endmodule
